pll_phase_sequencer: RTL and testbench

Sequences Cyclone III PLL dynamic phase-shift operations on behalf of two requesters: the serial command processor (port 0) and an automatic phase-scan engine (port 1). It arbitrates round-robin between them and generates `phasecounterselect`, `phaseupdown`, `phasestep` and `scanclk` for the PLL. It runs the step/`phasedone` handshake for an N-step move and reports completion or timeout. It sits between the command processor and the `altpll` reconfiguration ports, so no requester drives the PLL directly.

---
 rtl/pll_phase_sequencer.sv | 140 ++++++++++++++
 tb/tb_pll_phase_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_sequencer.sv
// pll_phase_sequencer: round-robin arbiter and phasestep/phasedone sequencer for Cyclone III PLL dynamic phase shift.
// scanclk is derived from clk; phasestep edges are aligned to scanclk falling edges.
module pll_phase_sequencer #(
  parameter int SCAN_DIV = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0_valid,
  input  logic [2:0] req0_sel,
  input  logic       req0_up,
  input  logic [7:0] req0_steps,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [2:0] req1_sel,
  input  logic       req1_up,
  input  logic [7:0] req1_steps,
  output logic       req1_ack,
  input  logic       phasedone,
  output logic [2:0] phasecounterselect,
  output logic       phaseupdown,
  output logic       phasestep,
  output logic       scanclk,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       grant_id,
  output logic [7:0] steps_done
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP, S_WAIT_LO, S_WAIT_HI, S_FINISH} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_pd_sync;
  logic [DW-1:0]   r_div;
  logic [TW-1:0]   r_to_cnt;
  logic [1:0]      r_tcnt;
  logic [2:0]      r_sel;
  logic [7:0]      r_remaining, r_steps_done;
  logic            r_scanclk, r_phasestep, r_up, r_grant_id, r_last_grant;
  logic            r_busy, r_done, r_err, r_ack0, r_ack1, r_err_flag;
  logic            w_g1, w_grant, w_run, w_tick, w_to, w_pd, w_to_err;
  logic [7:0]      w_steps;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_next = (w_steps == 8'd0) ? S_FINISH : S_SETUP;
      S_SETUP:   if (w_tick && r_tcnt != 2'd0 && r_scanclk) w_next = S_STEP;
      S_STEP:    if (w_tick && r_tcnt == 2'd3) w_next = S_WAIT_LO;
      S_WAIT_LO: if (!w_pd) w_next = S_WAIT_HI; else if (w_to) w_next = S_FINISH;
      S_WAIT_HI: if (w_pd) w_next = (r_remaining == 8'd1) ? S_FINISH : S_SETUP; else if (w_to) w_next = S_FINISH;
      default:   w_next = S_IDLE;
    endcase
  end

  // Port 1 wins only when port 0 is idle or port 0 was served last.
  always_comb begin
    w_g1     = req1_valid && (!req0_valid || !r_last_grant);
    w_grant  = (r_state == S_IDLE) && (req0_valid || req1_valid);
    w_steps  = w_g1 ? req1_steps : req0_steps;
    w_run    = r_state inside {S_SETUP, S_STEP, S_WAIT_LO, S_WAIT_HI};
    w_tick   = w_run && (r_div == DIV_MAX);
    w_to     = r_to_cnt == TO_MAX;
    w_pd     = r_pd_sync[1];
    w_to_err = w_to && ((r_state == S_WAIT_LO && w_pd) || (r_state == S_WAIT_HI && !w_pd));
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_pd_sync    <= 2'b00;
      r_div        <= '0;
      r_to_cnt     <= '0;
      r_tcnt       <= 2'd0;
      r_scanclk    <= 1'b0;
      r_phasestep  <= 1'b0;
      r_sel        <= 3'b000;
      r_up         <= 1'b1;
      r_remaining  <= 8'd0;
      r_steps_done <= 8'd0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err_flag   <= 1'b0;
    end else begin
      r_pd_sync <= {r_pd_sync[0], phasedone};
      r_div     <= (w_tick || !w_run) ? '0 : r_div + 1'b1;
      r_scanclk <= w_run && (w_next != S_FINISH) && (r_scanclk ^ w_tick);
      r_tcnt    <= (w_next != r_state) ? 2'd0 : r_tcnt + {1'b0, w_tick};
      r_to_cnt  <= (w_next != r_state) ? '0 : r_to_cnt + 1'b1;
      r_ack0    <= w_grant && !w_g1;
      r_ack1    <= w_grant && w_g1;
      r_done    <= (r_state == S_FINISH) && !r_err_flag;
      r_err     <= (r_state == S_FINISH) && r_err_flag;
      if (w_grant) begin
        r_sel        <= w_g1 ? req1_sel : req0_sel;
        r_up         <= w_g1 ? req1_up : req0_up;
        r_remaining  <= w_steps;
        r_grant_id   <= w_g1;
        r_steps_done <= 8'd0;
        r_busy       <= 1'b1;
        r_err_flag   <= 1'b0;
      end
      if (r_state == S_SETUP && w_next == S_STEP) r_phasestep <= 1'b1;
      if ((r_state == S_STEP && w_next == S_WAIT_LO) || r_state == S_FINISH) r_phasestep <= 1'b0;
      if (r_state == S_WAIT_HI && w_pd) begin
        r_steps_done <= r_steps_done + 8'd1;
        r_remaining  <= r_remaining - 8'd1;
      end
      if (w_to_err) r_err_flag <= 1'b1;
      if (r_state == S_FINISH) begin
        r_busy       <= 1'b0;
        r_last_grant <= r_grant_id;
      end
    end

  assign req0_ack           = r_ack0;
  assign req1_ack           = r_ack1;
  assign phasecounterselect = r_sel;
  assign phaseupdown        = r_up;
  assign phasestep          = r_phasestep;
  assign scanclk            = r_scanclk;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;
  assign grant_id           = r_grant_id;
  assign steps_done         = r_steps_done;
endmodule

// File: tb/tb_pll_phase_sequencer.sv
// tb_pll_phase_sequencer: scoreboard bench with a PLL phasedone model and a round-robin reference model.
module tb_pll_phase_sequencer;
  localparam int SD = 4, TO = 64, LIMIT = 30000;

  logic clk = 0, rstn = 1;
  logic req0_valid = 0, req1_valid = 0, req0_up = 0, req1_up = 0, phasedone = 1;
  logic [2:0] req0_sel = 0, req1_sel = 0;
  logic [7:0] req0_steps = 0, req1_steps = 0;
  logic req0_ack, req1_ack, phaseupdown, phasestep, scanclk, busy, done, err, grant_id;
  logic [2:0] phasecounterselect;
  logic [7:0] steps_done;

  pll_phase_sequencer #(.SCAN_DIV(SD), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_up(req0_up), .req0_steps(req0_steps), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_up(req1_up), .req1_steps(req1_steps), .req1_ack(req1_ack),
    .phasedone(phasedone), .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
    .phasestep(phasestep), .scanclk(scanclk), .busy(busy), .done(done), .err(err),
    .grant_id(grant_id), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  typedef struct {int port; logic [2:0] sel; logic up; int steps; bit err;} exp_t;
  exp_t sb[$];
  exp_t cur;
  bit cur_v = 0, sel_bad = 0, prev_ps = 0, prev_sc = 0, pd_stuck = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, model_last = 1;
  int ack_cyc = 0, rise_cyc = 0, fall_cyc = 0, done_cyc = -1000, pulses = 0, sclk_rises = 0;
  int ack_gap[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // PLL model: phasedone low 2 scanclk periods after phasestep falls, high again 3 periods later.
  initial forever begin
    @(negedge phasestep);
    if (!pd_stuck) begin
      repeat (4 * SD) @(negedge clk);
      phasedone = 0;
      repeat (6 * SD) @(negedge clk);
      phasedone = 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      cur_v = 0; prev_ps = 0; prev_sc = 0;
    end else begin
      if (req0_ack || req1_ack) begin
        if (sb.size() == 0) chk("unexpected_ack", {30'd0, req1_ack, req0_ack}, 0);
        else begin
          cur = sb.pop_front();
          cur_v = 1; ack_cyc = cyc; pulses = 0; sclk_rises = 0; sel_bad = 0;
          ack_gap[cur.port] = cyc - done_cyc;
          chk("ack_port", {30'd0, req1_ack, req0_ack}, cur.port ? 2 : 1);
          chk("ack_busy", busy, 1);
          chk("ack_grant_id", grant_id, cur.port);
          chk("ack_sel_up", {phasecounterselect, phaseupdown}, {cur.sel, cur.up});
          chk("ack_steps_done", steps_done, 0);
        end
      end
      if (busy && cur_v && {phasecounterselect, phaseupdown} !== {cur.sel, cur.up}) sel_bad = 1;
      if (phasestep && !prev_ps) begin
        pulses++; rise_cyc = cyc;
        chk("step_rise_scanclk", scanclk, 0);
      end
      if (!phasestep && prev_ps) begin
        fall_cyc = cyc;
        chk("step_width", cyc - rise_cyc, 4 * SD);
        chk("step_fall_scanclk", scanclk, 0);
      end
      if (scanclk && !prev_sc) sclk_rises++;
      if (done || err) begin
        if (!cur_v) chk("unexpected_completion", {30'd0, done, err}, 0);
        else begin
          chk("done_vs_err", {30'd0, done, err}, cur.err ? 1 : 2);
          chk("grant_id", grant_id, cur.port);
          chk("steps_done", steps_done, cur.err ? 0 : cur.steps);
          chk("step_pulses", pulses, cur.err ? 1 : cur.steps);
          chk("busy_fall", busy, 0);
          chk("sel_stable", sel_bad, 0);
          if (cur.steps == 0) begin
            chk("zero_latency", cyc - ack_cyc, 1);
            chk("zero_scanclk", sclk_rises, 0);
          end
          if (cur.err) chk("timeout_window", (cyc - fall_cyc >= TO) && (cyc - fall_cyc <= TO + 2), 1);
          cur_v = 0;
        end
        done_cyc = cyc;
      end
      prev_ps = phasestep; prev_sc = scanclk;
    end
  end

  task automatic request(input int p, input logic [2:0] s, input logic u, input logic [7:0] n);
    int k = 0;
    @(posedge clk); #1;
    if (p == 0) begin req0_sel = s; req0_up = u; req0_steps = n; req0_valid = 1; end
    else begin req1_sel = s; req1_up = u; req1_steps = n; req1_valid = 1; end
    do begin @(posedge clk); #1; k++; end while (!(p ? req1_ack : req0_ack) && k < LIMIT);
    chk("ack_seen", p ? req1_ack : req0_ack, 1);
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  function automatic exp_t mk(input int p, input logic [2:0] s, input logic u, input int n, input bit e);
    exp_t x;
    x.port = p; x.sel = s; x.up = u; x.steps = n; x.err = e;
    return x;
  endfunction

  task automatic issue_one(input int p, input logic [2:0] s, input logic u, input int n, input bit e);
    sb.push_back(mk(p, s, u, n, e));
    model_last = p;
    request(p, s, u, 8'(n));
  endtask

  // Both valid together: the port not granted last goes first.
  task automatic issue_pair(input logic [2:0] s0, input logic u0, input int n0,
                            input logic [2:0] s1, input logic u1, input int n1);
    int first = model_last ? 0 : 1;
    if (first == 0) begin sb.push_back(mk(0, s0, u0, n0, 0)); sb.push_back(mk(1, s1, u1, n1, 0)); end
    else begin sb.push_back(mk(1, s1, u1, n1, 0)); sb.push_back(mk(0, s0, u0, n0, 0)); end
    model_last = 1 - first;
    fork
      request(0, s0, u0, 8'(n0));
      request(1, s1, u1, 8'(n1));
    join
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || cur_v || busy) && k < LIMIT) begin @(negedge clk); k++; end
    chk("idle_reached", busy || (sb.size() != 0), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    #2 rstn = 0;
    repeat (5) @(posedge clk); #1;
    chk("rst_sel", phasecounterselect, 0);
    chk("rst_updown", phaseupdown, 1);
    chk("rst_phasestep", phasestep, 0);
    chk("rst_scanclk", scanclk, 0);
    chk("rst_acks", {req0_ack, req1_ack}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_steps_done", steps_done, 0);
    rstn = 1;
    repeat (50) @(posedge clk);

    issue_one(0, 3'b011, 1, 3, 0); wait_idle();
    issue_pair(3'b010, 1, 1, 3'b100, 0, 1); wait_idle();
    issue_pair(3'b001, 0, 1, 3'b110, 1, 1); wait_idle();
    issue_one(1, 3'b101, 0, 0, 0); wait_idle();

    pd_stuck = 1;
    issue_one(0, 3'b010, 1, 2, 1); wait_idle();
    pd_stuck = 0;

    sb.push_back(mk(0, 3'b011, 0, 5, 0));
    sb.push_back(mk(1, 3'b100, 1, 2, 0));
    model_last = 1;
    fork
      request(0, 3'b011, 0, 8'd5);
      begin repeat (40) @(posedge clk); request(1, 3'b100, 1, 8'd2); end
    join
    wait_idle();
    chk("holdoff_gap", ack_gap[1], 1);

    sb.push_back(mk(0, 3'b011, 1, 3, 0));
    request(0, 3'b011, 1, 8'd3);
    k = 0;
    while (!phasestep && k < LIMIT) begin @(negedge clk); k++; end
    chk("reached_step", phasestep, 1);
    #3 rstn = 0;
    #1;
    chk("rst_mid_phasestep", phasestep, 0);
    chk("rst_mid_scanclk", scanclk, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done_err", {done, err}, 0);
    sb.delete();
    model_last = 1;
    repeat (3) @(posedge clk); #1;
    rstn = 1;
    repeat (60) @(posedge clk);
    issue_one(1, 3'b110, 1, 2, 0); wait_idle();

    for (int i = 0; i < 20; i++) begin
      logic [2:0] s0 = 3'($urandom_range(0, 6)), s1 = 3'($urandom_range(0, 6));
      logic u0 = 1'($urandom), u1 = 1'($urandom);
      int n0 = $urandom_range(0, 6), n1 = $urandom_range(0, 6);
      if ($urandom_range(0, 2) == 0) issue_pair(s0, u0, n0, s1, u1, n1);
      else issue_one(int'($urandom_range(0, 1)), s0, u0, n0, 0);
      wait_idle();
    end

    issue_one(0, 3'b001, 0, 255, 0); wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
